// File: rtl/panel_frame_loader.sv
// RGB565 byte-stream to dual-bank panel RAM writer; top rows go to bank 1, bottom rows to bank 2.
// Define PANEL_DOUBLE_BUFFER_EN to write the back page and flip o_page after every frame.
module panel_frame_loader #(
  parameter int unsigned COL_BITS = 6,
  parameter int unsigned ROW_BITS = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sof,
  input  logic                         i_byte_valid,
  input  logic [7:0]                   i_byte,
  output logic                         o_byte_ready,
  output logic [COL_BITS+ROW_BITS-1:0] o_ram_wr_addr,
  output logic [15:0]                  o_ram_wr_data,
  output logic                         o_ram_b1_wr_en,
  output logic                         o_ram_b2_wr_en,
  output logic                         o_frame_done,
  output logic                         o_page
);

  localparam int unsigned IDX_W = COL_BITS + ROW_BITS;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    S_HI    = 2'd0,
    S_LO    = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [7:0]         r_hi, w_hi_nxt;
  logic [IDX_W-1:0]   r_addr, w_addr_nxt;
  logic [15:0]        r_data, w_data_nxt;
  logic               r_b1_wr_en, w_b1_nxt;
  logic               r_b2_wr_en, w_b2_nxt;
  logic               r_frame_done, w_done_nxt;
  logic               r_page, w_page_nxt;
  logic               w_ready;
  logic               w_xfer;
  logic               w_wr_page;

  assign w_ready = (r_state != S_WRITE) && !i_rst;
  assign w_xfer  = i_byte_valid && w_ready;

`ifdef PANEL_DOUBLE_BUFFER_EN
  assign w_wr_page = ~r_page;
`else
  assign w_wr_page = 1'b0;
`endif

  // Next-state and next-register values; sof overrides the normal byte sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_hi_nxt    = r_hi;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_b1_nxt    = 1'b0;
    w_b2_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_page_nxt  = r_page;

`ifdef PANEL_DOUBLE_BUFFER_EN
    if (r_frame_done) begin
      w_page_nxt = ~r_page;
    end
`else
    w_page_nxt = 1'b0;
`endif

    if (i_sof) begin
      w_idx_nxt   = '0;
      w_hi_nxt    = w_xfer ? i_byte : 8'h00;
      w_state_nxt = w_xfer ? S_LO : S_HI;
    end else begin
      case (r_state)
        S_HI: begin
          if (w_xfer) begin
            w_hi_nxt    = i_byte;
            w_state_nxt = S_LO;
          end
        end
        S_LO: begin
          if (w_xfer) begin
            w_data_nxt  = {r_hi, i_byte};
            w_addr_nxt  = {w_wr_page, r_idx[IDX_W-2:0]};
            w_b1_nxt    = ~r_idx[IDX_W-1];
            w_b2_nxt    = r_idx[IDX_W-1];
            w_done_nxt  = (r_idx == IDX_LAST);
            w_state_nxt = S_WRITE;
          end
        end
        S_WRITE: begin
          w_idx_nxt   = r_idx + IDX_W'(1);
          w_state_nxt = S_HI;
        end
        default: begin
          w_state_nxt = S_HI;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_HI;
      r_idx        <= '0;
      r_hi         <= 8'h00;
      r_addr       <= '0;
      r_data       <= 16'h0000;
      r_b1_wr_en   <= 1'b0;
      r_b2_wr_en   <= 1'b0;
      r_frame_done <= 1'b0;
      r_page       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_hi         <= w_hi_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_b1_wr_en   <= w_b1_nxt;
      r_b2_wr_en   <= w_b2_nxt;
      r_frame_done <= w_done_nxt;
      r_page       <= w_page_nxt;
    end
  end

  // Strobes are masked while reset is held so a reset landing on the write cycle drops the pixel.
  assign o_byte_ready   = w_ready;
  assign o_ram_wr_addr  = r_addr;
  assign o_ram_wr_data  = r_data;
  assign o_ram_b1_wr_en = r_b1_wr_en && !i_rst;
  assign o_ram_b2_wr_en = r_b2_wr_en && !i_rst;
  assign o_frame_done   = r_frame_done && !i_rst;
  assign o_page         = r_page;

endmodule

// File: tb/tb_panel_frame_loader.sv
// Directed self-checking bench for panel_frame_loader.
// Honours PANEL_DOUBLE_BUFFER_EN the same way as the design build.
module tb_panel_frame_loader;

`ifdef PANEL_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_sof;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic [11:0] o_ram_wr_addr;
  logic [15:0] o_ram_wr_data;
  logic        o_ram_b1_wr_en;
  logic        o_ram_b2_wr_en;
  logic        o_frame_done;
  logic        o_page;

  int n_assert = 0;
  int n_fail   = 0;
  int stray    = 0;

  panel_frame_loader dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_sof          (i_sof),
    .i_byte_valid   (i_byte_valid),
    .i_byte         (i_byte),
    .o_byte_ready   (o_byte_ready),
    .o_ram_wr_addr  (o_ram_wr_addr),
    .o_ram_wr_data  (o_ram_wr_data),
    .o_ram_b1_wr_en (o_ram_b1_wr_en),
    .o_ram_b2_wr_en (o_ram_b2_wr_en),
    .o_frame_done   (o_frame_done),
    .o_page         (o_page)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_addr(input int idx, input logic pg);
    logic [11:0] a;
    a = 12'(idx);
    a[11] = DB ? ~pg : 1'b0;
    return a;
  endfunction

  task automatic do_reset();
    i_rst        = 1'b1;
    i_sof        = 1'b0;
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
    step();
    step();
    i_rst = 1'b0;
    #1;
  endtask

  // One pixel in three cycles; returns what the write cycle showed.
  task automatic pix(input logic [7:0] hi, input logic [7:0] lo,
                     output logic b1, output logic b2, output logic done,
                     output logic [11:0] addr, output logic [15:0] data);
    i_byte_valid = 1'b1;
    i_byte       = hi;
    if (o_byte_ready !== 1'b1 || o_ram_b1_wr_en || o_ram_b2_wr_en) stray++;
    step();
    i_byte = lo;
    if (o_byte_ready !== 1'b1 || o_ram_b1_wr_en || o_ram_b2_wr_en) stray++;
    step();
    b1   = o_ram_b1_wr_en;
    b2   = o_ram_b2_wr_en;
    done = o_frame_done;
    addr = o_ram_wr_addr;
    data = o_ram_wr_data;
    if (o_byte_ready !== 1'b0) stray++;
    i_byte_valid = 1'b0;
    step();
  endtask

  initial begin
    logic        b1, b2, dn;
    logic [11:0] ad;
    logic [15:0] dt;
    logic [15:0] d;
    int          n_b1, n_b2, n_dn, k, n_we;
    logic [7:0]  bq [0:7];

    // Reset state
    i_rst = 1'b1; i_sof = 1'b0; i_byte_valid = 1'b1; i_byte = 8'h00;
    step();
    step();
    chk("rst_ready", 32'(o_byte_ready), 32'd0);
    chk("rst_b1", 32'(o_ram_b1_wr_en), 32'd0);
    chk("rst_b2", 32'(o_ram_b2_wr_en), 32'd0);
    chk("rst_done", 32'(o_frame_done), 32'd0);
    chk("rst_addr", 32'(o_ram_wr_addr), 32'd0);
    chk("rst_data", 32'(o_ram_wr_data), 32'd0);
    chk("rst_page", 32'(o_page), 32'd0);
    i_byte_valid = 1'b0;
    i_rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(o_byte_ready), 32'd1);

    // Test 1: first pixel and its successor
    pix(8'hF8, 8'h00, b1, b2, dn, ad, dt);
    chk("t1_b1", 32'(b1), 32'd1);
    chk("t1_b2", 32'(b2), 32'd0);
    chk("t1_addr", 32'(ad), 32'(exp_addr(0, 1'b0)));
    chk("t1_data", 32'(dt), 32'hF800);
    chk("t1_done", 32'(dn), 32'd0);
    chk("t1_hold_data", 32'(o_ram_wr_data), 32'hF800);
    pix(8'h07, 8'hE0, b1, b2, dn, ad, dt);
    chk("t1_addr2", 32'(ad), 32'(exp_addr(1, 1'b0)));
    chk("t1_data2", 32'(dt), 32'h07E0);

    // Test 2: full frame, bank split and wrap
    do_reset();
    n_b1 = 0; n_b2 = 0; n_dn = 0; stray = 0;
    for (int i = 0; i < 4096; i++) begin
      d = 16'(i * 7 + 3);
      pix(d[15:8], d[7:0], b1, b2, dn, ad, dt);
      n_b1 += int'(b1);
      n_b2 += int'(b2);
      n_dn += int'(dn);
      if (i == 0) begin
        chk("t2_p0_b1", 32'(b1), 32'd1);
        chk("t2_p0_addr", 32'(ad), 32'(exp_addr(0, 1'b0)));
      end
      if (i == 2047) begin
        chk("t2_p2047_b1", 32'(b1), 32'd1);
        chk("t2_p2047_addr", 32'(ad), 32'(exp_addr(2047, 1'b0)));
      end
      if (i == 2048) begin
        chk("t2_p2048_b2", 32'(b2), 32'd1);
        chk("t2_p2048_b1", 32'(b1), 32'd0);
        chk("t2_p2048_addr", 32'(ad), 32'(exp_addr(0, 1'b0)));
      end
      if (i == 4094) chk("t2_p4094_done", 32'(dn), 32'd0);
      if (i == 4095) begin
        chk("t2_p4095_b2", 32'(b2), 32'd1);
        chk("t2_p4095_addr", 32'(ad), 32'(exp_addr(2047, 1'b0)));
        chk("t2_p4095_done", 32'(dn), 32'd1);
        chk("t2_p4095_data", 32'(dt), 32'(16'(4095 * 7 + 3)));
      end
    end
    chk("t2_n_b1", 32'(n_b1), 32'd2048);
    chk("t2_n_b2", 32'(n_b2), 32'd2048);
    chk("t2_n_done", 32'(n_dn), 32'd1);
    chk("t2_stray", 32'(stray), 32'd0);
    chk("t2_page_after", 32'(o_page), DB ? 32'd1 : 32'd0);
    pix(8'h12, 8'h34, b1, b2, dn, ad, dt);
    chk("t2_f2_b1", 32'(b1), 32'd1);
    chk("t2_f2_addr", 32'(ad), 32'(exp_addr(0, DB)));
    chk("t2_f2_done", 32'(dn), 32'd0);

    // Test 3: sof alongside a byte discards the stored hi byte
    do_reset();
    pix(8'h11, 8'h22, b1, b2, dn, ad, dt);
    i_byte_valid = 1'b1; i_byte = 8'hAB;
    step();
    i_sof = 1'b1; i_byte = 8'h12;
    step();
    chk("t3_no_write_on_sof", 32'(o_ram_b1_wr_en | o_ram_b2_wr_en), 32'd0);
    i_sof = 1'b0; i_byte = 8'h34;
    step();
    chk("t3_b1", 32'(o_ram_b1_wr_en), 32'd1);
    chk("t3_addr", 32'(o_ram_wr_addr), 32'(exp_addr(0, 1'b0)));
    chk("t3_data", 32'(o_ram_wr_data), 32'h1234);
    i_byte_valid = 1'b0;
    step();
    pix(8'h55, 8'h66, b1, b2, dn, ad, dt);
    chk("t3_next_addr", 32'(ad), 32'(exp_addr(1, 1'b0)));

    // sof during the write cycle: write completes, counter restarts at 0
    pix(8'h77, 8'h88, b1, b2, dn, ad, dt);
    i_byte_valid = 1'b1; i_byte = 8'h9A;
    step();
    i_byte = 8'hBC;
    step();
    i_byte_valid = 1'b0; i_sof = 1'b1;
    chk("t3w_b1", 32'(o_ram_b1_wr_en), 32'd1);
    chk("t3w_addr", 32'(o_ram_wr_addr), 32'(exp_addr(3, 1'b0)));
    step();
    i_sof = 1'b0;
    pix(8'h01, 8'h02, b1, b2, dn, ad, dt);
    chk("t3w_restart_addr", 32'(ad), 32'(exp_addr(0, 1'b0)));

    // Test 4: continuous valid, ready cadence 1,1,0
    do_reset();
    bq[0] = 8'hC1; bq[1] = 8'hC2; bq[2] = 8'hC3; bq[3] = 8'hC4;
    bq[4] = 8'hC5; bq[5] = 8'hC6; bq[6] = 8'hC7; bq[7] = 8'hC8;
    k = 0; n_we = 0;
    i_byte_valid = 1'b1; i_byte = bq[0];
    for (int c = 0; c < 9; c++) begin
      logic rdy;
      rdy = o_byte_ready;
      chk("t4_ready", 32'(rdy), (c % 3 != 2) ? 32'd1 : 32'd0);
      step();
      if (rdy) begin
        k++;
        i_byte = bq[k];
      end
      n_we += int'(o_ram_b1_wr_en | o_ram_b2_wr_en);
      chk("t4_wr_en", 32'(o_ram_b1_wr_en | o_ram_b2_wr_en), (c % 3 == 1) ? 32'd1 : 32'd0);
      if (c % 3 == 1) chk("t4_data", 32'(o_ram_wr_data), 32'({bq[k-2], bq[k-1]}));
    end
    i_byte_valid = 1'b0;
    chk("t4_n_we", 32'(n_we), 32'd3);
    chk("t4_bytes_taken", 32'(k), 32'd6);

    // Test 5: reset between hi and lo drops the pixel
    do_reset();
    pix(8'hAA, 8'hBB, b1, b2, dn, ad, dt);
    i_byte_valid = 1'b1; i_byte = 8'hC3;
    step();
    i_byte_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("t5_ready_in_rst", 32'(o_byte_ready), 32'd0);
    step();
    chk("t5_no_we_rst", 32'(o_ram_b1_wr_en | o_ram_b2_wr_en), 32'd0);
    i_rst = 1'b0;
    step();
    chk("t5_no_we_after", 32'(o_ram_b1_wr_en | o_ram_b2_wr_en), 32'd0);
    pix(8'hDE, 8'hAD, b1, b2, dn, ad, dt);
    chk("t5_b1", 32'(b1), 32'd1);
    chk("t5_addr", 32'(ad), 32'(exp_addr(0, 1'b0)));
    chk("t5_data", 32'(dt), 32'hDEAD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
